// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-entry skid buffer between register read and the ALU,
// with optional write-back operand forwarding applied at capture time.
// Latency: 1 cycle from input transfer (in EMPTY) to out_valid.
// Backpressure: in_ready is registered and drops only when both entries are
// held, so upstream never needs a combinational path from out_ready.
// Ports: clk/rst (sync, active-high); in_* upstream operation + handshake;
//   fwd_* write-back result for forwarding; out_* registered ALU operation.
// Build option: define ALU_ISSUE_FORWARD_EN to compile in operand forwarding;
//   without it the fwd_* ports are present but ignored.

package alu_issue_pkg;
  typedef logic [3:0] alu_control_t;
endpackage

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [4:0]   in_rs1,
  input  logic [4:0]   in_rs2,
  input  logic         in_b_imm,
  input  alu_control_t in_control,
  input  logic [4:0]   in_rd,
  input  logic         fwd_valid,
  input  logic [4:0]   fwd_rd,
  input  logic [N-1:0] fwd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b,
  output alu_control_t out_control,
  output logic [4:0]   out_rd
);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    alu_control_t control;
    logic [4:0]   rd;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  entry_t head;   // oldest entry, drives out_*
  entry_t skid;   // second entry, only meaningful in FULL
  entry_t cap;    // incoming operation after forwarding

  logic in_fire, out_fire;
  logic load_head_in, load_head_skid, load_skid;

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Forwarding is resolved once, at capture; held entries never see later
  // write-backs.
  always_comb begin
    cap.a       = in_a;
    cap.b       = in_b;
    cap.control = in_control;
    cap.rd      = in_rd;
`ifdef ALU_ISSUE_FORWARD_EN
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_rs1))
      cap.a = fwd_data;
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_rs2) && !in_b_imm)
      cap.b = fwd_data;
`endif
  end

`ifndef ALU_ISSUE_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, in_rs1, in_rs2, in_b_imm};
`endif

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt    = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_head_in = 1'b1;          // pass-through: new op replaces head
        end else if (in_fire) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the output side can move.
        if (out_fire) begin
          state_nxt      = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      head     <= '0;
      skid     <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      if (load_head_in)
        head <= cap;
      else if (load_head_skid)
        head <= skid;
      if (load_skid)
        skid <= cap;
    end
  end

  assign out_a       = head.a;
  assign out_b       = head.b;
  assign out_control = head.control;
  assign out_rd      = head.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic, all
// checked against a FIFO-of-depth-2 reference model with forwarding at capture.
module tb_alu_issue_stage;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [N-1:0] in_a, in_b;
  logic [4:0]   in_rs1, in_rs2;
  logic         in_b_imm;
  logic [3:0]   in_control;
  logic [4:0]   in_rd;
  logic         fwd_valid;
  logic [4:0]   fwd_rd;
  logic [N-1:0] fwd_data;
  logic         out_valid, out_ready;
  logic [N-1:0] out_a, out_b;
  logic [3:0]   out_control;
  logic [4:0]   out_rd;

  always #5 clk = ~clk;

  alu_issue_stage #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_b_imm(in_b_imm), .in_control(in_control), .in_rd(in_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_control(out_control), .out_rd(out_rd)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   c;
    logic [4:0]   rd;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad = 0;
  int delivered = 0;

`ifdef ALU_ISSUE_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("out_a", {32'd0, out_a}, {32'd0, q[0].a});
      chk("out_b", {32'd0, out_b}, {32'd0, q[0].b});
      chk("out_control", {60'd0, out_control}, {60'd0, q[0].c});
      chk("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
    end
  endtask

  // Called on a negedge: check what the DUT shows, drive the next inputs,
  // advance the model across the coming posedge.
  task automatic cycle(input logic iv, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic imm,
                       input logic [3:0] c, input logic [4:0] rd, input logic ordy,
                       input logic fv, input logic [4:0] frd, input logic [N-1:0] fd);
    ent_t e;
    bit ofire, ifire;
    check_outputs();
    rst = 1'b0;
    in_valid = iv; in_a = a; in_b = b; in_rs1 = rs1; in_rs2 = rs2;
    in_b_imm = imm; in_control = c; in_rd = rd; out_ready = ordy;
    fwd_valid = fv; fwd_rd = frd; fwd_data = fd;
    ofire = ordy && (q.size() != 0);
    ifire = iv && (q.size() < 2);
    e.a = (FWD_EN && fv && frd != 0 && frd == rs1) ? fd : a;
    e.b = (FWD_EN && fv && frd != 0 && frd == rs2 && !imm) ? fd : b;
    e.c = c;
    e.rd = rd;
    if (ofire) begin
      void'(q.pop_front());
      delivered++;
    end
    if (ifire) q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic simple(input logic iv, input logic [N-1:0] a, input logic [3:0] c,
                        input logic [4:0] rd, input logic ordy);
    cycle(iv, a, a + 1, 5'd1, 5'd2, 1'b0, c, rd, ordy, 1'b0, 5'd0, '0);
  endtask

  task automatic do_reset(input logic iv, input logic ordy);
    rst = 1'b1; in_valid = iv; out_ready = ordy;
    in_a = 32'h1111_2222; in_b = 32'h3333_4444; in_control = 4'hF; in_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_a", {32'd0, out_a}, 64'd0);
    chk("rst_out_b", {32'd0, out_b}, 64'd0);
    chk("rst_out_control", {60'd0, out_control}, 64'd0);
    chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_rs1 = 0; in_rs2 = 0;
    in_b_imm = 0; in_control = 0; in_rd = 0; out_ready = 0;
    fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
    @(negedge clk);
    do_reset(1'b0, 1'b0);

    // Basic ADD capture with one-cycle latency.
    cycle(1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 1'b0, 4'd6, 5'd3, 1'b0, 1'b0, 5'd0, '0);
    chk("add_out_a", {32'd0, out_a}, 64'd5);
    chk("add_out_b", {32'd0, out_b}, 64'd7);
    chk("add_out_control", {60'd0, out_control}, 64'd6);
    simple(1'b0, 0, 0, 0, 1'b1);
    simple(1'b0, 0, 0, 0, 1'b0);

    // Stall: three offered with out_ready low, then drain in order.
    simple(1'b1, 32'hA1, 4'd1, 5'd1, 1'b0);
    simple(1'b1, 32'hA2, 4'd2, 5'd2, 1'b0);
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    simple(1'b1, 32'hA3, 4'd3, 5'd3, 1'b0);
    simple(1'b1, 32'hA3, 4'd3, 5'd3, 1'b0);
    d0 = delivered;
    simple(1'b1, 32'hA3, 4'd3, 5'd3, 1'b1);
    simple(1'b1, 32'hA3, 4'd3, 5'd3, 1'b1);
    simple(1'b0, 0, 0, 0, 1'b1);
    simple(1'b0, 0, 0, 0, 1'b1);
    chk("stall_delivered", 64'(delivered - d0), 64'd3);

    // Streaming with out_ready high: stays in ONE throughout.
    for (int i = 0; i < 8; i++) simple(1'b1, 32'h100 + i, 4'(i), 5'(i + 1), 1'b1);
    simple(1'b0, 0, 0, 0, 1'b1);

    // Forwarding: rs1 == rs2 == fwd_rd, b is immediate; then fwd_rd = 0.
    cycle(1'b1, 32'h11, 32'h22, 5'd4, 5'd4, 1'b1, 4'd6, 5'd5, 1'b1, 1'b1, 5'd4, 32'hDEADBEEF);
    chk("fwd_a", {32'd0, out_a}, FWD_EN ? 64'hDEADBEEF : 64'h11);
    chk("fwd_b_imm", {32'd0, out_b}, 64'h22);
    cycle(1'b1, 32'h33, 32'h44, 5'd4, 5'd4, 1'b0, 4'd6, 5'd5, 1'b1, 1'b1, 5'd4, 32'hCAFEF00D);
    chk("fwd_b_reg", {32'd0, out_b}, FWD_EN ? 64'hCAFEF00D : 64'h44);
    cycle(1'b1, 32'h55, 32'h66, 5'd0, 5'd0, 1'b0, 4'd6, 5'd5, 1'b1, 1'b1, 5'd0, 32'hDEADBEEF);
    chk("fwd_x0_a", {32'd0, out_a}, 64'h55);
    simple(1'b0, 0, 0, 0, 1'b1);

    // Reset while FULL with a handshake offered: nothing stale survives.
    simple(1'b1, 32'hB1, 4'd1, 5'd1, 1'b0);
    simple(1'b1, 32'hB2, 4'd2, 5'd2, 1'b0);
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) simple(1'b0, 0, 0, 0, 1'b1);

    // Random traffic with small register indices so forwarding hits often.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        cycle(1'($urandom_range(0, 2) != 0), $urandom, $urandom,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              4'($urandom), 5'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      end
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
